// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the mul_arbiter slice.
// Optional statistics counters are enabled by defining MUL_ARB_STATS_EN.
package mul_arb_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_MUL_LATENCY = 1;

    // Tag id is sized for the largest supported requester count (16).
    localparam int TAG_ID_W = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/mul_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first request strictly after the
// pointer; the pointer moves to the granted index when advance is high.
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    localparam int unsigned NUM_U = NUM_REQ;

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            found;
    int unsigned     cand;
    logic [ID_W-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned off = 1; off <= NUM_U; off++) begin
            cand     = (32'(ptr_q) + off) % NUM_U;
            cand_idx = ID_W'(cand);
            if (enable && !found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    always_comb begin
        ptr_d = advance ? grant_idx : ptr_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one registered multiplier among NUM_REQ requesters with round-robin
// grants and a tag pipeline routing results back. Define MUL_ARB_STATS_EN for counters.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       hold,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_in0,
    input  logic [NUM_REQ*WIDTH-1:0]   req_in1,
    output logic [WIDTH-1:0]           mul_in0,
    output logic [WIDTH-1:0]           mul_in1,
    input  logic [WIDTH-1:0]           mul_out,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]           resp_data
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [31:0]                busy_cycles,
    output logic [NUM_REQ*16-1:0]      grant_count
`endif
);

    localparam int ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               arb_en;
    logic               handshake;

    logic [WIDTH-1:0]   mul_in0_q, mul_in0_d;
    logic [WIDTH-1:0]   mul_in1_q, mul_in1_d;
    tag_t               tag_q [MUL_LATENCY];
    tag_t               tag_d [MUL_LATENCY];
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;

    assign arb_en = ~hold & ~reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       (req_valid),
        .enable    (arb_en),
        .advance   (handshake),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign handshake = |(req_valid & grant);

    // Operands only move on a handshake so idle cycles leave the multiplier quiet.
    always_comb begin
        mul_in0_d = mul_in0_q;
        mul_in1_d = mul_in1_q;
        if (handshake) begin
            mul_in0_d = req_in0[grant_idx*WIDTH +: WIDTH];
            mul_in1_d = req_in1[grant_idx*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
            tag_d[i] = '0;
        end
        tag_d[0].valid = handshake;
        tag_d[0].id    = TAG_ID_W'(grant_idx);
        for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // The final tag lines up with the multiplier output one edge later.
    always_comb begin
        resp_valid_d = '0;
        if (tag_q[MUL_LATENCY-1].valid) begin
            resp_valid_d = NUM_REQ'(1) << tag_q[MUL_LATENCY-1].id;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mul_in0_q    <= '0;
            mul_in1_q    <= '0;
            resp_valid_q <= '0;
            for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            mul_in0_q    <= mul_in0_d;
            mul_in1_q    <= mul_in1_d;
            resp_valid_q <= resp_valid_d;
            for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign mul_in0    = mul_in0_q;
    assign mul_in1    = mul_in1_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = mul_out;

`ifdef MUL_ARB_STATS_EN
    logic [31:0] busy_q, busy_d;
    logic [15:0] gcnt_q [NUM_REQ];
    logic [15:0] gcnt_d [NUM_REQ];

    always_comb begin
        busy_d = busy_q;
        if (tag_q[MUL_LATENCY-1].valid && (busy_q != '1)) begin
            busy_d = busy_q + 32'd1;
        end
        grant_count = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gcnt_d[i] = gcnt_q[i];
            if (handshake && grant[i] && (gcnt_q[i] != '1)) begin
                gcnt_d[i] = gcnt_q[i] + 16'd1;
            end
            grant_count[i*16 +: 16] = gcnt_q[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                gcnt_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                gcnt_q[i] <= gcnt_d[i];
            end
        end
    end

    assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a behavioural multiplier and
// round-robin reference model; stats checks are active under MUL_ARB_STATS_EN.
module tb_mul_arbiter;

    localparam int W = 8;
    localparam int N = 4;
    localparam int L = 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             hold = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_in0 = '0;
    logic [N*W-1:0]   req_in1 = '0;
    logic [W-1:0]     mul_in0, mul_in1, mul_out;
    logic [N-1:0]     resp_valid;
    logic [W-1:0]     resp_data;
`ifdef MUL_ARB_STATS_EN
    logic [31:0]      busy_cycles;
    logic [N*16-1:0]  grant_count;
`endif

    always #5 clock = ~clock;

    mul_arbiter #(
        .WIDTH       (W),
        .NUM_REQ     (N),
        .MUL_LATENCY (L)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in0    (req_in0),
        .req_in1    (req_in1),
        .mul_in0    (mul_in0),
        .mul_in1    (mul_in1),
        .mul_out    (mul_out),
        .resp_valid (resp_valid),
        .resp_data  (resp_data)
`ifdef MUL_ARB_STATS_EN
        ,
        .busy_cycles (busy_cycles),
        .grant_count (grant_count)
`endif
    );

    // Behavioural registered multiplier with L edges of latency.
    logic [W-1:0] mp [L];
    always @(posedge clock) begin
        mp[0] <= W'(mul_in0 * mul_in1);
        for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
    end
    assign mul_out = mp[L-1];

    typedef struct {
        int id;
        int data;
        int due;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           fails = 0;
    int           cyc = 0;
    int           last = N - 1;
    logic [W-1:0] exp_in0 = '0, exp_in1 = '0;
    logic [W-1:0] nxt_in0 = '0, nxt_in1 = '0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (!reset) begin
            exp_in0 <= nxt_in0;
            exp_in1 <= nxt_in1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard when a response is due, else expects silence.
    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("resp_valid", 64'(resp_valid), 64'(1 << e.id));
            check("resp_data", 64'(resp_data), 64'(e.data));
        end else begin
            check("resp_idle", 64'(resp_valid), 64'd0);
        end
        check("mul_in0", 64'(mul_in0), 64'(exp_in0));
        check("mul_in1", 64'(mul_in1), 64'(exp_in1));
    end

    task automatic drive(input logic [N-1:0] v, input logic h,
                         input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        int   g;
        exp_t e;
        @(posedge clock);
        #1;
        req_valid = v;
        hold      = h;
        req_in0   = a;
        req_in1   = b;
        #1;
        g = -1;
        if (!h) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && v[(last + k) % N]) g = (last + k) % N;
            end
        end
        check("req_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'd0);
        if (g >= 0) begin
            last    = g;
            nxt_in0 = a[g*W +: W];
            nxt_in1 = b[g*W +: W];
            e.id    = g;
            e.data  = (int'(a[g*W +: W]) * int'(b[g*W +: W])) % (1 << W);
            e.due   = cyc + 1 + L;
            q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset     = 1'b1;
        req_valid = '1;
        hold      = 1'b0;
        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mul_in0", 64'(mul_in0), 64'd0);
        check("rst_mul_in1", 64'(mul_in1), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        q.delete();
        last    = N - 1;
        exp_in0 = '0;
        exp_in1 = '0;
        nxt_in0 = '0;
        nxt_in1 = '0;
        @(negedge clock);
        @(negedge clock);
        reset     = 1'b0;
        req_valid = '0;
    endtask

    task automatic drain();
        repeat (L + 3) drive('0, 1'b0, '0, '0);
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    logic [N*W-1:0] a, b;

    initial begin
        #1 reset = 1'b1;
        do_reset();

        a = '0; b = '0;
        a[0*W +: W] = 8'd3;
        b[0*W +: W] = 8'd5;
        drive(4'b0001, 1'b0, a, b);
        check("first_grant", 64'(req_ready), 64'b0001);
        drain();

        do_reset();
        for (int i = 0; i < N; i++) begin
            a[i*W +: W] = W'(i + 1);
            b[i*W +: W] = W'(2);
        end
        repeat (8) drive('1, 1'b0, a, b);
        drain();
`ifdef MUL_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            check("grant_count", 64'(grant_count[i*16 +: 16]), 64'd2);
        end
        check("busy_cycles", 64'(busy_cycles), 64'd8);
`endif

        a = '0; b = '0;
        a[2*W +: W] = 8'd200;
        b[2*W +: W] = 8'd3;
        drive(4'b0100, 1'b0, a, b);
        drain();

        for (int i = 0; i < N; i++) begin
            a[i*W +: W] = W'(10 + i);
            b[i*W +: W] = W'(7 + 3 * i);
        end
        drive(4'b0010, 1'b0, a, b);
        drive(4'b1000, 1'b0, a, b);
        repeat (3) drive('1, 1'b1, a, b);
        drain();

        drive(4'b0001, 1'b0, a, b);
        do_reset();
        drive('1, 1'b0, a, b);
        check("post_reset_grant", 64'(req_ready), 64'b0001);
        drain();

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                a[i*W +: W] = W'($urandom_range(0, 255));
                b[i*W +: W] = W'($urandom_range(0, 255));
            end
            drive(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 4) == 0), a, b);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one registered multiplier (`mul`, output `out` of WIDTH bits) between NUM_REQ requesters.
- Grants one operand pair per cycle using round-robin order.
- Drives the multiplier's operand registers and tracks each in-flight op's requester ID through a tag pipeline matched to the multiplier latency, so every result is routed back to its requester.
- Sits between the requester logic and the `mul` instance in the energy-characterisation datapath. Idle operands are held stable, so idle cycles produce no multiplier toggling.

Parameters:
- WIDTH, 8, operand/result width; the product is truncated to the low WIDTH bits.
- NUM_REQ, 4, number of requesters (2..16).
- MUL_LATENCY, 1, clock edges from the multiplier input change to a valid `out`.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- hold  in  1  when high, no new grants are issued; in-flight ops drain normally.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  one-hot grant; the handshake completes at a rising edge with valid&ready.
- req_in0  in  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_in1  in  NUM_REQ*WIDTH  packed operand B, same packing.
- mul_in0  out  WIDTH  registered operand to the multiplier.
- mul_in1  out  WIDTH  registered operand to the multiplier.
- mul_out  in  WIDTH  multiplier result.
- resp_valid  out  NUM_REQ  one-hot result strobe, one cycle.
- resp_data  out  WIDTH  equals mul_out; meaningful only while resp_valid is nonzero.

Behaviour:
- Reset (async, immediate):
  - mul_in0 and mul_in1 go to 0.
  - The round-robin pointer goes to NUM_REQ-1, so requester 0 has first priority.
  - All tag-pipeline valids clear, so resp_valid is 0.
  - In-flight ops are discarded and never reported.
  - req_ready is 0 while reset is high.
- Grant (combinational):
  - If hold=0 and any req_valid is set, req_ready is one-hot on the first valid requester strictly after the pointer, searching cyclically. Otherwise req_ready=0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- On a handshake edge E0:
  - The granted requester's operands load into mul_in0/mul_in1.
  - Tag stage 0 loads {valid=1, id=granted index}.
  - The pointer moves to the granted index.
- Without a handshake:
  - mul_in0/mul_in1 hold their value; no toggling.
  - Tag stage 0 loads valid=0.
  - The pointer is unchanged.
- Tag pipeline:
  - MUL_LATENCY stages, shifted every edge.
  - resp_valid = onehot(id) of the final stage when it is valid; resp_data = mul_out.
  - A result is therefore visible in the cycle after edge E0+MUL_LATENCY.
- Throughput is one op per cycle. Back-to-back grants and back-to-back responses are allowed. There is no response backpressure; requesters must accept resp_valid.
- A hold rising mid-stream does not block ops already granted; they still return.
- A single requester holding valid is granted every cycle. With all requesters valid, the grant order is 0,1,2,3,0,...
- The arithmetic is the multiplier's; the arbiter never modifies the data.

Optional Feature:
- MUL_ARB_STATS_EN
- Defined:
  - Adds output busy_cycles (32 bits), which counts edges where the final tag stage is valid.
  - Adds output grant_count (NUM_REQ*16 bits), one 16-bit counter per requester, incremented on that requester's handshake.
  - Both saturate at all-ones and are reset to 0 by reset.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Package mul_arb_pkg:
  - ID_W = $clog2(NUM_REQ) helper function.
  - Tag struct {valid, id}.
  - Default WIDTH and MUL_LATENCY constants.
- One sub-module: rr_arbiter. It has the request vector, enable (=~hold) and advance inputs, and produces the one-hot grant and index; it owns the pointer.

Test Plan:
- Reset, then req0 valid with in0=3, in1=5, hold=0 -> req_ready=0001 in the same cycle; mul_in0=3 and mul_in1=5 after E0; resp_valid=0001 and resp_data=15 in the cycle after E1.
- All four requesters valid for 8 cycles, with operands (i+1, 2) -> grant order 0,1,2,3,0,1,2,3; responses 2,4,6,8 repeating, each on the matching resp_valid bit, one per cycle.
- req2 sends in0=200, in1=3 with WIDTH=8 -> resp_data=88 (600 mod 256) on resp_valid=0100.
- Issue to req1 and req3 back to back, then raise hold with all valid -> req_ready=0 while hold is high; both pending responses still arrive; mul_in0/mul_in1 stay constant.
- Grant req0, then assert reset before its response edge -> resp_valid is never asserted for that op; all outputs are 0 immediately; the next grant goes to req0.
- With MUL_ARB_STATS_EN, after the 8-cycle all-valid run -> grant_count = 2 for each requester; busy_cycles = 8.
